// File: rtl/aip_slave_ctrl_if.sv
// AIP host bus bundle: strobes, config select and data.
// Host drives via master, the controller listens via slave.
interface aip_slave_ctrl_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int CONFIG_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]   aip_dataIn;
  logic [DATA_WIDTH-1:0]   aip_dataOut;
  logic [CONFIG_WIDTH-1:0] aip_config;
  logic                    aip_read;
  logic                    aip_write;
  logic                    aip_start;
  logic                    aip_int;

  modport master (
    output aip_dataIn,
    output aip_config,
    output aip_read,
    output aip_write,
    output aip_start,
    input  aip_dataOut,
    input  aip_int
  );

  modport slave (
    input  aip_dataIn,
    input  aip_config,
    input  aip_read,
    input  aip_write,
    input  aip_start,
    output aip_dataOut,
    output aip_int
  );
endinterface

// File: rtl/aip_slave_ctrl.sv
// AIP slave front end: register map, auto-increment memory
// channels, W1C interrupt block and core start sequencer.
module aip_slave_ctrl #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          CONFIG_WIDTH   = 5,
  parameter int          NUM_MEMS       = 2,
  parameter int          MEM_ADDR_WIDTH = 8,
  parameter int          NUM_INTS       = 8,
  parameter logic [31:0] IP_ID          = 32'h00001001
) (
  input  logic                               clk,
  input  logic                               rst_n,
  aip_slave_ctrl_if.slave                    aip,
  output logic                               core_start,
  input  logic                               core_busy,
  input  logic [NUM_INTS-1:0]                core_int_set,
  output logic [NUM_MEMS-1:0]                mem_wr_en,
  output logic [NUM_MEMS*MEM_ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0]              mem_wr_data,
  output logic [NUM_MEMS*MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [NUM_MEMS*DATA_WIDTH-1:0]     mem_rd_data
);

  localparam int AW = MEM_ADDR_WIDTH;
  localparam int CW = CONFIG_WIDTH;
  localparam logic [CW-1:0] CFG_ENA = CW'(29);
  localparam logic [CW-1:0] CFG_STA = CW'(30);
  localparam logic [CW-1:0] CFG_ID  = CW'(31);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT
  } st_t;

  logic                  r_rd_s, r_rd_d;
  logic                  r_wr_s, r_wr_d;
  logic                  r_st_s, r_st_d;
  logic [CW-1:0]         r_cfg;
  logic [DATA_WIDTH-1:0] r_din;

  logic                  w_rd_edge;
  logic                  w_wr_edge;
  logic                  w_st_edge;
  logic [NUM_MEMS-1:0]   w_hit_dat;
  logic [NUM_MEMS-1:0]   w_hit_ptr;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic [NUM_INTS-1:0]   w_clr;

  logic [AW-1:0]         r_ptr     [NUM_MEMS];
  logic [AW-1:0]         r_wr_addr [NUM_MEMS];
  logic [DATA_WIDTH-1:0] r_pf      [NUM_MEMS];
  logic [NUM_MEMS-1:0]   r_wr_en;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic [DATA_WIDTH-1:0] r_dout;
  logic [NUM_INTS-1:0]   r_ena;
  logic [NUM_INTS-1:0]   r_flags;
  logic                  r_int;
  st_t                   r_state;
  logic                  r_core_start;

  assign w_rd_edge = r_rd_s & ~r_rd_d;
  assign w_wr_edge = r_wr_s & ~r_wr_d;
  assign w_st_edge = r_st_s & ~r_st_d;

  // Sample strobes once, keep a delayed copy for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_s <= 1'b0;
      r_rd_d <= 1'b0;
      r_wr_s <= 1'b0;
      r_wr_d <= 1'b0;
      r_st_s <= 1'b0;
      r_st_d <= 1'b0;
      r_cfg  <= '0;
      r_din  <= '0;
    end else begin
      r_rd_s <= aip.aip_read;
      r_rd_d <= r_rd_s;
      r_wr_s <= aip.aip_write;
      r_wr_d <= r_wr_s;
      r_st_s <= aip.aip_start;
      r_st_d <= r_st_s;
      r_cfg  <= aip.aip_config;
      r_din  <= aip.aip_dataIn;
    end
  end

  // Channel k owns config 2k (data) and 2k+1 (pointer)
  always_comb begin
    w_hit_dat = '0;
    w_hit_ptr = '0;
    for (int k = 0; k < NUM_MEMS; k++) begin
      w_hit_dat[k] = (r_cfg == CW'(2 * k));
      w_hit_ptr[k] = (r_cfg == CW'(2 * k + 1));
    end
  end

  // Read mux; unmapped configs fall through to zero
  always_comb begin
    w_rd_val = '0;
    if (r_cfg == CFG_ID) begin
      w_rd_val = DATA_WIDTH'(IP_ID);
    end else if (r_cfg == CFG_STA) begin
      w_rd_val[NUM_INTS-1:0]   = r_flags;
      w_rd_val[DATA_WIDTH-1]   = core_busy;
    end else if (r_cfg == CFG_ENA) begin
      w_rd_val[NUM_INTS-1:0]   = r_ena;
    end
    for (int k = 0; k < NUM_MEMS; k++) begin
      if (w_hit_ptr[k]) w_rd_val = DATA_WIDTH'(r_ptr[k]);
      if (w_hit_dat[k]) w_rd_val = r_pf[k];
    end
  end

  // Pointers, write pulses and continuously refreshed prefetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_MEMS; k++) begin
        r_ptr[k]     <= '0;
        r_wr_addr[k] <= '0;
        r_pf[k]      <= '0;
      end
      r_wr_en   <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= '0;
      for (int k = 0; k < NUM_MEMS; k++) begin
        r_pf[k] <= mem_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
        if (w_wr_edge && w_hit_ptr[k]) begin
          r_ptr[k] <= r_din[AW-1:0];
        end else if (w_wr_edge && w_hit_dat[k]) begin
          r_wr_en[k]   <= 1'b1;
          r_wr_addr[k] <= r_ptr[k];
          r_ptr[k]     <= r_ptr[k] + 1'b1;
        end else if (w_rd_edge && w_hit_dat[k]) begin
          r_ptr[k]     <= r_ptr[k] + 1'b1;
        end
      end
      if (w_wr_edge && |w_hit_dat) r_wr_data <= r_din;
    end
  end

  assign w_clr = (w_wr_edge && r_cfg == CFG_STA) ?
                 r_din[NUM_INTS-1:0] : '0;

  // Read data, enables and W1C flags; a set beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= '0;
      r_ena   <= '0;
      r_flags <= '0;
      r_int   <= 1'b0;
    end else begin
      if (w_rd_edge) r_dout <= w_rd_val;
      if (w_wr_edge && r_cfg == CFG_ENA)
        r_ena <= r_din[NUM_INTS-1:0];
      r_flags <= (r_flags & ~w_clr) | core_int_set;
      r_int   <= |(r_flags & r_ena);
    end
  end

  // Start sequencer: one pulse per accepted start, then wait idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_core_start <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_core_start <= 1'b0;
          if (w_st_edge && !core_busy) begin
            r_state      <= S_PULSE;
            r_core_start <= 1'b1;
          end
        end
        S_PULSE: begin
          r_core_start <= 1'b0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          r_core_start <= 1'b0;
          if (!core_busy) r_state <= S_IDLE;
        end
        default: begin
          r_core_start <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign aip.aip_dataOut = r_dout;
  assign aip.aip_int     = r_int;
  assign core_start      = r_core_start;
  assign mem_wr_en       = r_wr_en;
  assign mem_wr_data     = r_wr_data;

  for (genvar g = 0; g < NUM_MEMS; g++) begin : g_ch
    assign mem_wr_addr[g*AW +: AW] = r_wr_addr[g];
    assign mem_rd_addr[g*AW +: AW] = r_ptr[g];
  end

endmodule

// File: tb/tb_aip_slave_ctrl.sv
// Directed bench for aip_slave_ctrl: vector table for bus
// accesses plus hand sequences for W1C, start and reset.
module tb_aip_slave_ctrl;

  localparam int DW = 32;
  localparam int NM = 2;
  localparam int AW = 8;
  localparam int NI = 8;

  logic            clk;
  logic            rst_n;
  logic            core_start;
  logic            core_busy;
  logic [NI-1:0]   core_int_set;
  logic [NM-1:0]   mem_wr_en;
  logic [NM*AW-1:0] mem_wr_addr;
  logic [DW-1:0]   mem_wr_data;
  logic [NM*AW-1:0] mem_rd_addr;
  logic [NM*DW-1:0] mem_rd_data;

  aip_slave_ctrl_if #(.DATA_WIDTH(DW), .CONFIG_WIDTH(5)) aip ();

  aip_slave_ctrl #(
    .DATA_WIDTH(DW), .CONFIG_WIDTH(5), .NUM_MEMS(NM),
    .MEM_ADDR_WIDTH(AW), .NUM_INTS(NI), .IP_ID(32'h00001001)
  ) dut (
    .clk(clk), .rst_n(rst_n), .aip(aip.slave),
    .core_start(core_start), .core_busy(core_busy),
    .core_int_set(core_int_set),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [NM][256];

  always @(posedge clk) begin
    for (int k = 0; k < NM; k++) begin
      if (mem_wr_en[k]) mem[k][mem_wr_addr[k*AW +: AW]] <= mem_wr_data;
      mem_rd_data[k*DW +: DW] <= mem[k][mem_rd_addr[k*AW +: AW]];
    end
  end

  typedef struct {
    int            ch;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wl_t;
  wl_t wlog[$];
  int  n_pulse;

  always @(negedge clk) begin
    for (int k = 0; k < NM; k++)
      if (mem_wr_en[k])
        wlog.push_back('{k, mem_wr_addr[k*AW +: AW], mem_wr_data});
    if (core_start) n_pulse++;
  end

  int n_chk;
  int n_err;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] c, input logic [DW-1:0] d);
    @(negedge clk);
    aip.aip_config = c;
    aip.aip_dataIn = d;
    aip.aip_write  = 1'b1;
    repeat (3) @(negedge clk);
    aip.aip_write  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [4:0] c, output logic [DW-1:0] q);
    @(negedge clk);
    aip.aip_config = c;
    aip.aip_read   = 1'b1;
    repeat (3) @(negedge clk);
    q = aip.aip_dataOut;
    aip.aip_read   = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_strobe();
    @(negedge clk);
    aip.aip_start = 1'b1;
    repeat (3) @(negedge clk);
    aip.aip_start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    bit            rd;
    logic [4:0]    cfg;
    logic [DW-1:0] din;
    bit            busy;
    logic [DW-1:0] exp;
  } vec_t;

  localparam int NV = 18;
  vec_t vec [NV];

  logic [DW-1:0] q;
  int            nlog;

  initial begin
    n_chk = 0;
    n_err = 0;
    n_pulse = 0;
    for (int k = 0; k < NM; k++)
      for (int a = 0; a < 256; a++) mem[k][a] = '0;
    mem[1][3] = 32'h11;
    mem[1][4] = 32'h22;

    vec[0]  = '{1'b1, 5'd31, 32'h0,  1'b0, 32'h00001001};
    vec[1]  = '{1'b1, 5'd30, 32'h0,  1'b1, 32'h80000000};
    vec[2]  = '{1'b1, 5'd7,  32'h0,  1'b0, 32'h0};
    vec[3]  = '{1'b0, 5'd1,  32'h4,  1'b0, 32'h0};
    vec[4]  = '{1'b0, 5'd0,  32'hA,  1'b0, 32'h0};
    vec[5]  = '{1'b0, 5'd0,  32'hB,  1'b0, 32'h0};
    vec[6]  = '{1'b0, 5'd0,  32'hC,  1'b0, 32'h0};
    vec[7]  = '{1'b1, 5'd1,  32'h0,  1'b0, 32'h7};
    vec[8]  = '{1'b0, 5'd3,  32'h3,  1'b0, 32'h0};
    vec[9]  = '{1'b1, 5'd2,  32'h0,  1'b0, 32'h11};
    vec[10] = '{1'b1, 5'd2,  32'h0,  1'b0, 32'h22};
    vec[11] = '{1'b1, 5'd3,  32'h0,  1'b0, 32'h5};
    vec[12] = '{1'b0, 5'd1,  32'hFF, 1'b0, 32'h0};
    vec[13] = '{1'b0, 5'd0,  32'hD,  1'b0, 32'h0};
    vec[14] = '{1'b0, 5'd0,  32'hE,  1'b0, 32'h0};
    vec[15] = '{1'b1, 5'd1,  32'h0,  1'b0, 32'h1};
    vec[16] = '{1'b0, 5'd29, 32'h5,  1'b0, 32'h0};
    vec[17] = '{1'b1, 5'd29, 32'h0,  1'b0, 32'h5};

    aip.aip_config = '0;
    aip.aip_dataIn = '0;
    aip.aip_read   = 1'b0;
    aip.aip_write  = 1'b0;
    aip.aip_start  = 1'b0;
    core_busy      = 1'b0;
    core_int_set   = '0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_dout", aip.aip_dataOut, 32'h0);
    chk("rst_int", {31'h0, aip.aip_int}, 32'h0);
    chk("rst_start", {31'h0, core_start}, 32'h0);
    chk("rst_wren", {30'h0, mem_wr_en}, 32'h0);
    chk("rst_rdaddr", {16'h0, mem_rd_addr}, 32'h0);

    for (int i = 0; i < NV; i++) begin
      core_busy = vec[i].busy;
      if (vec[i].rd) begin
        bus_rd(vec[i].cfg, q);
        chk($sformatf("vec%0d", i), q, vec[i].exp);
      end else begin
        bus_wr(vec[i].cfg, vec[i].din);
      end
    end
    core_busy = 1'b0;

    chk("wlog_n", wlog.size(), 5);
    if (wlog.size() == 5) begin
      chk("wl0", {wlog[0].ch[7:0], 16'h0, wlog[0].a}, 32'h00000004);
      chk("wl0d", wlog[0].d, 32'hA);
      chk("wl1", {wlog[1].ch[7:0], 16'h0, wlog[1].a}, 32'h00000005);
      chk("wl1d", wlog[1].d, 32'hB);
      chk("wl2", {wlog[2].ch[7:0], 16'h0, wlog[2].a}, 32'h00000006);
      chk("wl2d", wlog[2].d, 32'hC);
      chk("wl3_wrap", {24'h0, wlog[3].a}, 32'hFF);
      chk("wl3d", wlog[3].d, 32'hD);
      chk("wl4_wrap", {24'h0, wlog[4].a}, 32'h00);
      chk("wl4d", wlog[4].d, 32'hE);
    end

    @(negedge clk);
    core_int_set = 8'h04;
    @(negedge clk);
    core_int_set = 8'h00;
    repeat (3) @(negedge clk);
    chk("int_set", {31'h0, aip.aip_int}, 32'h1);

    aip.aip_config = 5'd30;
    aip.aip_dataIn = 32'h4;
    aip.aip_write  = 1'b1;
    @(negedge clk);
    core_int_set = 8'h04;
    @(negedge clk);
    core_int_set = 8'h00;
    repeat (2) @(negedge clk);
    aip.aip_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("int_setwins", {31'h0, aip.aip_int}, 32'h1);
    bus_rd(5'd30, q);
    chk("sta_setwins", q, 32'h4);

    bus_wr(5'd30, 32'h0);
    chk("int_w0", {31'h0, aip.aip_int}, 32'h1);
    bus_wr(5'd30, 32'h4);
    chk("int_w1c", {31'h0, aip.aip_int}, 32'h0);
    bus_rd(5'd30, q);
    chk("sta_w1c", q, 32'h0);

    @(negedge clk);
    core_int_set = 8'h02;
    @(negedge clk);
    core_int_set = 8'h00;
    repeat (3) @(negedge clk);
    chk("int_masked", {31'h0, aip.aip_int}, 32'h0);
    bus_rd(5'd30, q);
    chk("sta_masked", q, 32'h2);

    start_strobe();
    chk("start_one", n_pulse, 1);
    core_busy = 1'b1;
    start_strobe();
    chk("start_busy", n_pulse, 1);
    core_busy = 1'b0;
    repeat (2) @(negedge clk);

    nlog = wlog.size();
    aip.aip_config = 5'd0;
    aip.aip_dataIn = 32'h77;
    aip.aip_write  = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rr_dout", aip.aip_dataOut, 32'h0);
    chk("rr_wren", {30'h0, mem_wr_en}, 32'h0);
    chk("rr_wdata", mem_wr_data, 32'h0);
    chk("rr_rdaddr", {16'h0, mem_rd_addr}, 32'h0);
    chk("rr_int", {31'h0, aip.aip_int}, 32'h0);
    chk("rr_start", {31'h0, core_start}, 32'h0);
    aip.aip_write = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rr_nowrite", wlog.size(), nlog);
    bus_rd(5'd1, q);
    chk("rr_ptr0", q, 32'h0);
    bus_rd(5'd0, q);
    chk("rr_pf0", q, 32'hE);
    bus_rd(5'd30, q);
    chk("rr_sta", q, 32'h0);
    start_strobe();
    chk("rr_start_ok", n_pulse, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/aip_slave_ctrl.md
Name: aip_slave_ctrl

Overview:
- Parametrised AIP slave controller: decodes the host-side AIP strobe/config bus into register accesses, NUM_MEMS auto-incrementing memory channels, a W1C interrupt/status block and a core start pulse.
- Sits between the AIP bus and the processing core; next-generation, width/channel-generic version of the AIP register front end.

Parameters:
- DATA_WIDTH, 32, AIP data bus width (>=16).
- CONFIG_WIDTH, 5, aip_config width.
- NUM_MEMS, 2, memory channels, 1..14.
- MEM_ADDR_WIDTH, 8, per-channel address width; depth = 2**MEM_ADDR_WIDTH.
- NUM_INTS, 8, interrupt sources, 1..DATA_WIDTH-1.
- IP_ID, 32'h00001001, value returned at ID config.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- aip_dataIn  in  DATA_WIDTH  write data
- aip_dataOut  out  DATA_WIDTH  read data
- aip_config  in  CONFIG_WIDTH  register select
- aip_read  in  1  read strobe (level, acted on rising edge)
- aip_write  in  1  write strobe (level, acted on rising edge)
- aip_start  in  1  start strobe (rising edge)
- aip_int  out  1  interrupt request
- core_start  out  1  one-cycle start pulse to core
- core_busy  in  1  core running
- core_int_set  in  NUM_INTS  per-source one-cycle set pulses
- mem_wr_en  out  NUM_MEMS  per-channel write enable
- mem_wr_addr  out  NUM_MEMS*MEM_ADDR_WIDTH  flattened write addresses
- mem_wr_data  out  DATA_WIDTH  shared write data
- mem_rd_addr  out  NUM_MEMS*MEM_ADDR_WIDTH  flattened read addresses
- mem_rd_data  in  NUM_MEMS*DATA_WIDTH  read data, 1-cycle sync read

Behaviour:
- Clock and reset: one clock clk; rst_n asynchronous, active-low. Reset clears all outputs, pointers, flags, enables and prefetch registers to 0 immediately.
- Strobes: aip_read/aip_write/aip_start registered once, then rising-edge detected; exactly one action per assertion regardless of length. Host keeps >=3 cycles between strobe rising edges.
- Config map:
  - Channel k: 2k = DATA port, 2k+1 = POINTER.
  - 29 = INT_ENABLE (RW, bits [NUM_INTS-1:0]).
  - 30 = STATUS: flags [NUM_INTS-1:0] W1C; bit DATA_WIDTH-1 = core_busy, RO.
  - 31 = ID (RO).
  - Other addresses read 0; writes ignored.
- POINTER write: ptr_k <= aip_dataIn[MEM_ADDR_WIDTH-1:0]; issues a prefetch.
- POINTER read: returns ptr_k zero-extended.
- DATA write: mem_wr_en[k]=1 for exactly one cycle, 1 cycle after the edge, with mem_wr_addr_k=ptr_k and mem_wr_data=aip_dataIn; ptr_k increments in the same cycle.
- Prefetch: mem_rd_addr_k driven = ptr_k at all times; prefetch_k captures mem_rd_data_k 2 cycles after any ptr_k change.
- DATA read: aip_dataOut <= prefetch_k 1 cycle after the read edge; ptr_k increments; next prefetch valid before the next allowed strobe.
- Register reads: aip_dataOut <= selected value 1 cycle after the edge; aip_dataOut holds between reads.
- Pointer wrap: 2**MEM_ADDR_WIDTH-1 increments to 0 silently, no flag.
- Interrupts:
  - flag[i] set by core_int_set[i].
  - Cleared by STATUS write with bit i = 1; writing 0 leaves the flag unchanged.
  - Simultaneous set and clear on the same bit: set wins.
  - aip_int registered = |(flags & enable).
- Start state machine, IDLE -> PULSE -> WAIT:
  - IDLE: aip_start edge with core_busy=0 -> PULSE; with core_busy=1 the edge is dropped.
  - PULSE: core_start=1 for one cycle -> WAIT.
  - WAIT: returns to IDLE when core_busy=0; a start edge in WAIT is dropped.
- Reset mid-operation: any pending write pulse, start pulse or prefetch is abandoned. After release the state is IDLE, all ptrs are 0, and prefetch refills from address 0 within 2 cycles.

Test Plan:
- Reset, then read config 31 -> aip_dataOut=0x00001001. Read config 30 with core_busy=1 -> 0x80000000. Read config 7 -> 0.
- Write ptr0=4, then DATA0 writes 0xA,0xB,0xC -> mem_wr_en[0] pulses with addr 4,5,6 and matching data. Read ptr0 -> 7.
- Memory model loaded with addr3=0x11, addr4=0x22. Write ptr1=3, then two DATA1 reads -> 0x11, 0x22; ptr1=5.
- Write ptr0=0xFF, then two DATA0 writes -> addresses 0xFF, then 0x00.
- Set enable=0x05, then pulse core_int_set=0x04 -> aip_int=1. Write STATUS=0x04 in the same cycle as a new core_int_set[2] pulse -> flag stays 1. A clean W1C write -> aip_int=0.
- aip_start with core_busy=0 -> single core_start pulse. Second start while busy -> no pulse. Drop rst_n mid DATA write -> no mem_wr_en, all outputs 0.
